adc_packet_capture: RTL and testbench
=====================================

Name: adc_packet_capture

Overview:
- Capture engine between the ADC16DV160 receive path (16-bit samples already deserialized into the clk domain) and the AXI DMA S2MM stream input in the digitizer.
- Software writes a packet size and a start bit through a small register port.
- The block then packs the next PACKET_SIZE bytes of ADC samples into 32-bit AXI-Stream beats and marks the final beat with tlast.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit output FIFO entries (power of 2, >= 4).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- adc_data  input  16  ADC sample, valid when adc_valid=1
- adc_valid  input  1  one sample per cycle when high
- reg_addr  input  4  byte address of the register (0x0, 0x4, 0x8)
- reg_wr  input  1  write strobe, one cycle
- reg_wdata  input  32  write data
- reg_rd  input  1  read strobe, one cycle
- reg_rdata  output  32  read data, registered
- reg_rvalid  output  1  high for one cycle, one clock after reg_rd
- m_axis_tdata  output  32  stream data
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready
- m_axis_tlast  output  1  last beat of packet
- busy  output  1  capture or drain in progress

Behaviour:
- Reset: all outputs 0; PACKET_SIZE=0; FIFO empty; state IDLE; DONE=0; OVERFLOW=0.
- Register map:
  - 0x0 CONTROL: write bit0=1 issues start; reads return 0.
  - 0x4 STATUS: bit0 busy, bit1 DONE, bit2 OVERFLOW. Writing 1 to bit1 or bit2 clears that bit.
  - 0x8 PACKET_SIZE: bytes, read/write. Bits [1:0] are forced to 0 on write.
  - Unmapped addresses read 0; writes to them are ignored.
- Read: reg_rdata and reg_rvalid update on the edge after reg_rd. reg_rdata holds its value until the next read.
- States and transitions:
  - IDLE -> CAPTURE on a start write when PACKET_SIZE != 0. Start with PACKET_SIZE == 0 is ignored.
  - Start entry clears DONE, OVERFLOW, the word counter and the pending half-word.
  - CAPTURE -> DRAIN when word count reaches PACKET_SIZE/4.
  - DRAIN -> IDLE on the cycle the tlast beat handshakes (tvalid & tready). DONE is set on that cycle.
  - Start writes while in CAPTURE or DRAIN are ignored.
- busy is 1 in CAPTURE and DRAIN. It is combinational from state and is 0 in the cycle after returning to IDLE.
- Packing:
  - In CAPTURE, the first valid sample goes to tdata[15:0] and the second to tdata[31:16].
  - The word is pushed to the FIFO on the cycle the second sample arrives.
  - Samples arriving in IDLE or DRAIN are discarded.
- Counting: the word counter increments on each pushed word. The pushed word that makes count == PACKET_SIZE/4 carries last=1 in the FIFO. No further samples are accepted after it.
- Overflow: if the FIFO is full when a word is ready, the word is dropped, OVERFLOW is set, and the counter does not increment. The packet therefore still has exactly PACKET_SIZE/4 beats.
- FIFO:
  - First-word-fall-through. m_axis_tvalid = !empty; tdata/tlast come from the head entry.
  - Pop on tvalid & tready.
  - Simultaneous push and pop when full is allowed; the push is accepted.
- tvalid, once asserted, stays high with stable tdata until tready.
- Reset mid-packet: immediate return to IDLE, FIFO flushed, no tlast emitted.
- Minimum latency: first beat is visible on tvalid 1 cycle after the second sample is captured.

Test Plan:
- Basic packet: write PACKET_SIZE=2048, start; ADC stream alternating 0x00FF, 0xFF00 continuously with tready=1.
  - Exactly 512 beats, all 0xFF0000FF.
  - tlast only on beat 512; DONE=1, busy=0 afterwards; STATUS reads 0x2.
- Register access: write 0x8=0x0000_0807, read back -> 0x0000_0804. Read 0x0 -> 0. Read 0xC -> 0.
- Zero size: PACKET_SIZE=0, start -> busy stays 0, no tvalid, DONE stays 0.
- Backpressure: PACKET_SIZE=256, tready=0 while streaming.
  - FIFO fills to 16 words; OVERFLOW=1.
  - After tready=1, still exactly 64 beats with tlast on the 64th.
  - Write 0x4=0x4 clears OVERFLOW.
- Start while busy: second start during CAPTURE ignored; beat count unchanged. Start after completion starts a new packet and clears DONE.
- Async reset during CAPTURE: tvalid, busy, reg_rvalid drop immediately. Next start produces a full clean packet.

Source files
------------

// File: rtl/adc_packet_capture.sv
// ============================================================================
//  Module   : adc_packet_capture
//  Brief    : Packs 16-bit ADC samples into 32-bit AXI-Stream beats of a
//             software-programmed byte length, with tlast on the final beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module adc_packet_capture #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] adc_data,
   input  logic        adc_valid,
   input  logic [3:0]  reg_addr,
   input  logic        reg_wr,
   input  logic [31:0] reg_wdata,
   input  logic        reg_rd,
   output logic [31:0] reg_rdata,
   output logic        reg_rvalid,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        busy
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam logic [c_ptr_w:0] c_ptr_one = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [31:0]   r_packet_size;
   logic          r_done;
   logic          r_overflow;
   logic [29:0]   r_word_cnt;
   logic [15:0]   r_half;
   logic          r_half_valid;
   logic [31:0]   r_rdata;
   logic          r_rvalid;

   logic [32:0]   r_mem [FIFO_DEPTH];
   logic [c_ptr_w:0] r_wr_ptr;
   logic [c_ptr_w:0] r_rd_ptr;

   logic          w_start;
   logic          w_sample_in;
   logic          w_word_ready;
   logic          w_word_last;
   logic [31:0]   w_word;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_overflow;
   logic [32:0]   w_head;
   logic [31:0]   w_rd_mux;

   assign w_start      = reg_wr && (reg_addr == 4'h0) && reg_wdata[0] &&
                         (r_state == ST_IDLE) && (r_packet_size != 32'd0);
   assign w_sample_in  = (r_state == ST_CAPTURE) && adc_valid;
   assign w_word_ready = w_sample_in && r_half_valid;
   assign w_word       = {adc_data, r_half};
   assign w_word_last  = (r_word_cnt + 30'd1) >= r_packet_size[31:2];

   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                         (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
   assign w_pop        = !w_empty && m_axis_tready;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push       = w_word_ready && (!w_full || w_pop);
   assign w_overflow   = w_word_ready && !w_push;
   assign w_head       = r_mem[r_rd_ptr[c_ptr_w-1:0]];

   assign m_axis_tvalid = !w_empty;
   assign m_axis_tdata  = w_empty ? 32'd0 : w_head[31:0];
   assign m_axis_tlast  = w_empty ? 1'b0  : w_head[32];
   assign reg_rdata     = r_rdata;
   assign reg_rvalid    = r_rvalid;

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start)
               w_state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            busy = 1'b1;
            if (w_push && w_word_last)
               w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (w_pop && m_axis_tlast)
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_rd_mux = 32'd0;
      case (reg_addr)
         4'h4:    w_rd_mux = {29'd0, r_overflow, r_done, busy};
         4'h8:    w_rd_mux = r_packet_size;
         default: w_rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_packet_size <= 32'd0;
         r_done        <= 1'b0;
         r_overflow    <= 1'b0;
         r_word_cnt    <= 30'd0;
         r_half        <= 16'd0;
         r_half_valid  <= 1'b0;
         r_rdata       <= 32'd0;
         r_rvalid      <= 1'b0;
      end else begin
         r_rvalid <= reg_rd;
         if (reg_rd)
            r_rdata <= w_rd_mux;
         if (reg_wr && (reg_addr == 4'h8))
            r_packet_size <= {reg_wdata[31:2], 2'b00};

         if (w_start) begin
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_cnt   <= 30'd0;
            r_half_valid <= 1'b0;
         end else begin
            if (w_sample_in) begin
               if (!r_half_valid)
                  r_half <= adc_data;
               r_half_valid <= !r_half_valid;
            end
            if (w_push)
               r_word_cnt <= r_word_cnt + 30'd1;

            // Hardware events take precedence over a same-cycle software clear.
            if (reg_wr && (reg_addr == 4'h4)) begin
               if (reg_wdata[1])
                  r_done <= 1'b0;
               if (reg_wdata[2])
                  r_overflow <= 1'b0;
            end
            if (w_overflow)
               r_overflow <= 1'b1;
            if ((r_state == ST_DRAIN) && w_pop && m_axis_tlast)
               r_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {w_word_last, w_word};
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_packet_capture.sv
// ============================================================================
//  Module   : tb_adc_packet_capture
//  Brief    : Directed self-checking bench for adc_packet_capture.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_packet_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] adc_data;
   logic        adc_valid;
   logic [3:0]  reg_addr;
   logic        reg_wr;
   logic [31:0] reg_wdata;
   logic        reg_rd;
   logic [31:0] reg_rdata;
   logic        reg_rvalid;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   int          beat_cnt = 0;
   int          exp_beats = 0;
   bit          inc_mode = 1'b0;
   bit          adc_en   = 1'b0;
   bit          toggle   = 1'b0;
   logic [15:0] inc_val  = 16'd1;
   logic [31:0] rd_val;
   logic [31:0] exp_w;

   adc_packet_capture #(.FIFO_DEPTH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .reg_addr      (reg_addr),
      .reg_wr        (reg_wr),
      .reg_wdata     (reg_wdata),
      .reg_rd        (reg_rd),
      .reg_rdata     (reg_rdata),
      .reg_rvalid    (reg_rvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
      tick();
      reg_wr    = 1'b1;
      reg_addr  = addr;
      reg_wdata = data;
      tick();
      reg_wr    = 1'b0;
   endtask

   task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
      tick();
      reg_rd   = 1'b1;
      reg_addr = addr;
      tick();
      reg_rd   = 1'b0;
      check("rvalid", {31'd0, reg_rvalid}, 32'd1);
      data = reg_rdata;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_packet(input logic [31:0] size, input bit mode, input int nbeats);
      adc_en    = 1'b0;
      inc_mode  = mode;
      exp_beats = nbeats;
      beat_cnt  = 0;
      reg_write(4'h8, size);
      reg_write(4'h0, 32'd1);
      adc_en = 1'b1;
      wait_idle(4000);
      adc_en = 1'b0;
      check("beats", beat_cnt, nbeats);
   endtask

   // ADC source: alternating 0x00FF/0xFF00 or an incrementing ramp from 1.
   always begin
      @(posedge clk);
      #1;
      if (adc_en) begin
         adc_valid = 1'b1;
         if (inc_mode) begin
            adc_data = inc_val;
            inc_val  = inc_val + 16'd1;
         end else begin
            adc_data = toggle ? 16'hFF00 : 16'h00FF;
            toggle   = ~toggle;
         end
      end else begin
         adc_valid = 1'b0;
         adc_data  = 16'd0;
         toggle    = 1'b0;
         inc_val   = 16'd1;
      end
   end

   always @(negedge clk) begin
      if (!reset && m_axis_tvalid && m_axis_tready) begin
         exp_w = inc_mode ? {16'(2 * beat_cnt + 2), 16'(2 * beat_cnt + 1)} : 32'hFF0000FF;
         check("tdata", m_axis_tdata, exp_w);
         check("tlast", {31'd0, m_axis_tlast}, {31'd0, (beat_cnt + 1 == exp_beats)});
         beat_cnt++;
      end
   end

   initial begin
      reset         = 1'b1;
      reg_addr      = 4'h0;
      reg_wr        = 1'b0;
      reg_wdata     = 32'd0;
      reg_rd        = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_busy",   {31'd0, busy},          32'd0);
      check("rst_rvalid", {31'd0, reg_rvalid},    32'd0);
      check("rst_rdata",  reg_rdata,              32'd0);
      check("rst_tdata",  m_axis_tdata,           32'd0);
      check("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
      reg_read(4'h8, rd_val); check("rst_size",   rd_val, 32'd0);
      reg_read(4'h4, rd_val); check("rst_status", rd_val, 32'd0);

      // Register access
      reg_write(4'h8, 32'h0000_0807);
      reg_read(4'h8, rd_val); check("size_rb", rd_val, 32'h0000_0804);
      tick();
      check("rvalid_pulse", {31'd0, reg_rvalid}, 32'd0);
      check("rdata_hold",   reg_rdata,           32'h0000_0804);
      reg_read(4'h0, rd_val); check("ctrl_rd",  rd_val, 32'd0);
      reg_read(4'hC, rd_val); check("unmap_rd", rd_val, 32'd0);
      reg_write(4'hC, 32'hFFFF_FFFF);
      reg_read(4'h8, rd_val); check("unmap_wr", rd_val, 32'h0000_0804);

      // Zero size start is ignored
      reg_write(4'h8, 32'd0);
      reg_write(4'h0, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("zero_busy",   {31'd0, busy},          32'd0);
         check("zero_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      end
      reg_read(4'h4, rd_val); check("zero_status", rd_val, 32'd0);

      // Basic 2048-byte packet
      run_packet(32'd2048, 1'b0, 512);
      check("basic_busy", {31'd0, busy}, 32'd0);
      reg_read(4'h4, rd_val); check("basic_status", rd_val, 32'h2);

      // Sample ordering with a ramp
      run_packet(32'd16, 1'b1, 4);
      reg_read(4'h4, rd_val); check("ramp_status", rd_val, 32'h2);

      // Backpressure and overflow
      m_axis_tready = 1'b0;
      inc_mode  = 1'b0;
      exp_beats = 64;
      beat_cnt  = 0;
      reg_write(4'h8, 32'd256);
      reg_write(4'h0, 32'd1);
      adc_en = 1'b1;
      repeat (80) tick();
      check("bp_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      reg_read(4'h4, rd_val); check("bp_status", rd_val, 32'h5);
      m_axis_tready = 1'b1;
      wait_idle(4000);
      adc_en = 1'b0;
      check("bp_beats", beat_cnt, 64);
      reg_read(4'h4, rd_val); check("bp_done_ovf", rd_val, 32'h6);
      reg_write(4'h4, 32'h4);
      reg_read(4'h4, rd_val); check("ovf_clear", rd_val, 32'h2);

      // Start while busy is ignored; start after completion restarts
      exp_beats = 16;
      beat_cnt  = 0;
      reg_write(4'h8, 32'd64);
      reg_write(4'h0, 32'd1);
      adc_en = 1'b1;
      repeat (8) tick();
      reg_write(4'h0, 32'd1);
      wait_idle(4000);
      adc_en = 1'b0;
      check("sb_beats", beat_cnt, 16);
      reg_read(4'h4, rd_val); check("sb_status", rd_val, 32'h2);
      beat_cnt = 0;
      reg_write(4'h0, 32'd1);
      reg_read(4'h4, rd_val); check("restart_status", rd_val, 32'h1);
      adc_en = 1'b1;
      wait_idle(4000);
      adc_en = 1'b0;
      check("restart_beats", beat_cnt, 16);

      // Asynchronous reset during capture
      m_axis_tready = 1'b0;
      exp_beats = 512;
      beat_cnt  = 0;
      reg_write(4'h8, 32'd2048);
      reg_write(4'h0, 32'd1);
      adc_en = 1'b1;
      repeat (20) tick();
      check("pre_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("pre_rst_busy",   {31'd0, busy},          32'd1);
      tick();
      reg_rd   = 1'b1;
      reg_addr = 4'h4;
      tick();
      reg_rd = 1'b0;
      check("pre_rst_rvalid", {31'd0, reg_rvalid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("arst_busy",   {31'd0, busy},          32'd0);
      check("arst_rvalid", {31'd0, reg_rvalid},    32'd0);
      adc_en = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      m_axis_tready = 1'b1;
      check("arst_no_beats", beat_cnt, 0);
      run_packet(32'd256, 1'b0, 64);
      reg_read(4'h4, rd_val); check("post_rst_status", rd_val, 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
